// File: rtl/gate_hold_fsm.sv
// Noise gate: opens after ATTACK_N consecutive detector hits and closes after HOLD_N consecutive misses.
// Latency: audio 1 cycle, gate state 1 cycle after det_valid. There is no backpressure; the inputs are strobe-qualified.
module gate_hold_fsm #(
    parameter int WIDTH    = 16,
    parameter int ATTACK_N = 4,
    parameter int HOLD_N   = 2400,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] det_in,
    input  logic                    det_valid,
    input  logic signed [WIDTH-1:0] audio_in,
    input  logic                    audio_valid,
    output logic signed [WIDTH-1:0] audio_out,
    output logic                    audio_out_valid,
    output logic                    gate_open,
    output logic                    open_pulse,
    output logic                    close_pulse
);

    typedef enum logic [1:0] {CLOSED, ATTACK, OPEN, HOLD} state_t;

    localparam logic [CNT_W-1:0] ATTACK_LIM = CNT_W'(ATTACK_N);
    localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_N);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             det_hit;

    assign det_hit = |det_in;
    assign cnt_inc = cnt + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLOSED;
            cnt         <= '0;
            gate_open   <= 1'b0;
            open_pulse  <= 1'b0;
            close_pulse <= 1'b0;
        end else begin
            open_pulse  <= 1'b0;
            close_pulse <= 1'b0;
            if (det_valid) begin
                case (state)
                    CLOSED: begin
                        if (!det_hit) begin
                            cnt <= '0;
                        end else if (ATTACK_N == 1) begin
                            state      <= OPEN;
                            cnt        <= '0;
                            gate_open  <= 1'b1;
                            open_pulse <= 1'b1;
                        end else begin
                            state <= ATTACK;
                            cnt   <= CNT_ONE;
                        end
                    end
                    ATTACK: begin
                        if (!det_hit) begin
                            state <= CLOSED;
                            cnt   <= '0;
                        end else if (cnt_inc == ATTACK_LIM) begin
                            state      <= OPEN;
                            cnt        <= '0;
                            gate_open  <= 1'b1;
                            open_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    OPEN: begin
                        if (det_hit) begin
                            cnt <= '0;
                        end else if (HOLD_N == 1) begin
                            state       <= CLOSED;
                            cnt         <= '0;
                            gate_open   <= 1'b0;
                            close_pulse <= 1'b1;
                        end else begin
                            state <= HOLD;
                            cnt   <= CNT_ONE;
                        end
                    end
                    default: begin // HOLD: a hit retriggers silently
                        if (det_hit) begin
                            state <= OPEN;
                            cnt   <= '0;
                        end else if (cnt_inc == HOLD_LIM) begin
                            state       <= CLOSED;
                            cnt         <= '0;
                            gate_open   <= 1'b0;
                            close_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                endcase
            end
        end
    end

    // Gating uses the pre-edge gate_open, so a same-cycle transition affects the next sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_out       <= '0;
            audio_out_valid <= 1'b0;
        end else begin
            audio_out_valid <= audio_valid;
            if (audio_valid)
                audio_out <= gate_open ? audio_in : '0;
        end
    end

endmodule

// File: tb/tb_gate_hold_fsm.sv
// Directed-vector bench for gate_hold_fsm with ATTACK_N=3, HOLD_N=4, WIDTH=16.
module tb_gate_hold_fsm;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] det_in = '0;
    logic               det_valid = 1'b0;
    logic signed [15:0] audio_in = '0;
    logic               audio_valid = 1'b0;
    logic signed [15:0] audio_out;
    logic               audio_out_valid;
    logic               gate_open;
    logic               open_pulse;
    logic               close_pulse;

    int vectors = 0;
    int miscompares = 0;

    gate_hold_fsm #(.WIDTH(16), .ATTACK_N(3), .HOLD_N(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .det_in(det_in), .det_valid(det_valid),
        .audio_in(audio_in), .audio_valid(audio_valid),
        .audio_out(audio_out), .audio_out_valid(audio_out_valid),
        .gate_open(gate_open), .open_pulse(open_pulse), .close_pulse(close_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of strobes from a negedge; return at the next negedge with the results visible
    task automatic step(input logic dv, input int d, input logic av, input int a);
        @(negedge clk);
        det_valid   = dv;
        det_in      = 16'(d);
        audio_valid = av;
        audio_in    = 16'(a);
        @(negedge clk);
        det_valid   = 1'b0;
        audio_valid = 1'b0;
    endtask

    task automatic det(input int d);
        step(1'b1, d, 1'b0, 0);
    endtask

    task automatic gate_chk(input string tag, input int g, input int op, input int cp);
        chk({tag, ".gate"}, int'(gate_open), g);
        chk({tag, ".open_pulse"}, int'(open_pulse), op);
        chk({tag, ".close_pulse"}, int'(close_pulse), cp);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.audio_out", int'(audio_out), 0);
        chk("rst.audio_out_valid", int'(audio_out_valid), 0);
        gate_chk("rst", 0, 0, 0);
        rst_n = 1'b1;

        // Closed gate mutes audio
        step(1'b0, 0, 1'b1, 1000);
        chk("closed.audio_out", int'(audio_out), 0);
        chk("closed.audio_out_valid", int'(audio_out_valid), 1);
        chk("closed.gate", int'(gate_open), 0);
        step(1'b0, 0, 1'b0, 1234);
        chk("idle.audio_out_valid", int'(audio_out_valid), 0);
        chk("idle.audio_out_hold", int'(audio_out), 0);

        // Detector hits without det_valid must be ignored
        for (int i = 0; i < 5; i++) step(1'b0, 1, 1'b0, 0);
        gate_chk("unqualified", 0, 0, 0);

        // Three spaced hits open the gate
        det(1); gate_chk("att1", 0, 0, 0);
        step(1'b0, 0, 1'b0, 0);
        det(1); gate_chk("att2", 0, 0, 0);
        step(1'b0, 0, 1'b0, 0);
        det(1); gate_chk("att3", 1, 1, 0);
        step(1'b0, 0, 1'b1, -32768);
        gate_chk("open.after", 1, 0, 0);
        chk("open.audio_min", int'(audio_out), -32768);
        chk("open.audio_valid", int'(audio_out_valid), 1);

        // Hold with retrigger, then close on the 4th trailing zero with same-cycle audio
        det(0); det(0); det(0);
        gate_chk("hold3", 1, 0, 0);
        det(1); gate_chk("retrigger", 1, 0, 0);
        det(0); det(0); det(0);
        gate_chk("hold3b", 1, 0, 0);
        step(1'b1, 0, 1'b1, 500);
        gate_chk("close", 0, 0, 1);
        chk("close.audio_pre", int'(audio_out), 500);
        step(1'b0, 0, 1'b1, 500);
        chk("close.audio_next", int'(audio_out), 0);
        chk("close.pulse_drop", int'(close_pulse), 0);

        // Attack interrupted by a zero restarts the count
        det(1); det(1); det(0); det(1); det(1);
        gate_chk("att_reset", 0, 0, 0);
        det(1); gate_chk("att_reopen", 1, 1, 0);

        // Reset mid-HOLD discards the count
        det(0); det(0);
        gate_chk("hold2", 1, 0, 0);
        step(1'b0, 0, 1'b1, 77);
        chk("hold2.audio", int'(audio_out), 77);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        gate_chk("async_rst", 0, 0, 0);
        chk("async_rst.audio_out", int'(audio_out), 0);
        chk("async_rst.audio_out_valid", int'(audio_out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            det(0);
            gate_chk($sformatf("post_rst%0d", i), 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gate_hold_fsm.md
GATE_HOLD_FSM -- requirements
Module: gate_hold_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 16: audio/detector sample width in bits.
REQ-002 SHALL have parameter ATTACK_N, default 4: consecutive above-threshold detector samples required to open the gate; legal range 1..2^CNT_W-1.
REQ-003 SHALL have parameter HOLD_N, default 2400: consecutive below-threshold detector samples required to close the gate; legal range 1..2^CNT_W-1.
REQ-004 SHALL have parameter CNT_W, default 16: counter width.
REQ-005 SHALL have port clk  input  1: sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-007 SHALL have port det_in  input  signed WIDTH: level-detector flag; nonzero = above threshold, zero = below.
REQ-008 SHALL have port det_valid  input  1: det_in is qualified this cycle.
REQ-009 SHALL have port audio_in  input  signed WIDTH: raw audio sample.
REQ-010 SHALL have port audio_valid  input  1: audio_in is qualified this cycle.
REQ-011 SHALL have port audio_out  output  signed WIDTH: gated audio sample.
REQ-012 SHALL have port audio_out_valid  output  1: audio_out is qualified this cycle.
REQ-013 SHALL have port gate_open  output  1: registered gate state; 1 in OPEN or HOLD.
REQ-014 SHALL have port open_pulse  output  1: one-cycle strobe on the CLOSED/ATTACK-to-OPEN transition.
REQ-015 SHALL have port close_pulse  output  1: one-cycle strobe on the HOLD-to-CLOSED transition.

Function
REQ-016 SHALL implement four states: CLOSED, ATTACK, OPEN, HOLD, plus one counter cnt of CNT_W bits.
REQ-017 SHALL evaluate state transitions only in cycles with det_valid=1; state and cnt SHALL hold otherwise.
REQ-018 CLOSED, det nonzero: ATTACK_N=1 -> OPEN, assert open_pulse; else -> ATTACK, cnt=1. CLOSED, det zero: remain, cnt=0.
REQ-019 ATTACK, det nonzero: if cnt+1==ATTACK_N -> OPEN, cnt=0, assert open_pulse; else cnt=cnt+1. ATTACK, det zero: -> CLOSED, cnt=0, no pulse.
REQ-020 OPEN, det zero: HOLD_N=1 -> CLOSED, assert close_pulse; else -> HOLD, cnt=1. OPEN, det nonzero: remain, cnt=0.
REQ-021 HOLD, det zero: if cnt+1==HOLD_N -> CLOSED, cnt=0, assert close_pulse; else cnt=cnt+1. HOLD, det nonzero: -> OPEN, cnt=0, no open_pulse (retrigger).
REQ-022 open_pulse and close_pulse SHALL be registered, high exactly one cycle, coincident with the first cycle of the new gate_open value; never both high.
REQ-023 gate_open SHALL be registered and update in the same cycle as the state register.
REQ-024 On audio_valid=1, audio_out SHALL load audio_in if gate_open (pre-edge value) is 1, else 0; audio_out_valid SHALL be 1 the following cycle (latency 1).
REQ-025 With audio_valid=0, audio_out_valid SHALL be 0 and audio_out SHALL hold its last value.
REQ-026 det_valid and audio_valid in the same cycle: audio SHALL be gated with the pre-transition gate_open; the transition takes effect for the next audio sample.
REQ-027 Audio path SHALL pass samples bit-exact (no scaling, no saturation), including most-negative value.
REQ-028 cnt SHALL never wrap; transition conditions guarantee cnt < ATTACK_N or < HOLD_N.

Reset
REQ-029 rst_n low SHALL asynchronously force state=CLOSED, cnt=0, gate_open=0, open_pulse=0, close_pulse=0, audio_out=0, audio_out_valid=0.
REQ-030 Reset mid-ATTACK or mid-HOLD SHALL discard the count; no pulse SHALL be emitted on or after reset release until a new qualifying sequence.
REQ-031 After rst_n deassertion the first det_valid cycle SHALL be evaluated from CLOSED.

Verification (ATTACK_N=3, HOLD_N=4, WIDTH=16)
REQ-032 Reset then audio_in=1000 valid with det idle -> audio_out=0, audio_out_valid=1 one cycle later, gate_open=0.
REQ-033 det=1 on 3 spaced det_valid strobes -> gate_open rises and open_pulse high one cycle after the 3rd; next audio_in=-32768 -> audio_out=-32768.
REQ-034 det 1,1,0,1,1 -> gate stays closed (attack reset by the zero); one more 1 -> opens.
REQ-035 Open, then det 0,0,0,1,0,0,0,0 -> stays open through retrigger, no open_pulse on retrigger; close_pulse after the 4th trailing zero, gate_open=0.
REQ-036 Same-cycle det_valid (closing 4th zero) and audio_valid with audio_in=500 -> audio_out=500; next audio sample -> 0.
REQ-037 rst_n pulsed low mid-HOLD (cnt=2) -> all outputs 0 immediately; subsequent det zeros produce no close_pulse.
